v_rams_bwe_sp: RTL and testbench
================================

# v_rams_bwe_sp

Parametrised single-port block RAM with NB_COL byte-lane write enables, a selectable write mode, an optional output pipeline register and a post-reset clear sequencer. It is the general successor to the fixed two-byte, write-first byte-enable RAM in the HDL_Coding_Techniques RAM set. It is intended for register files, packet buffers and descriptor stores that need partial-word writes and a known-zero start state.

## Interface
- NB_COL, 4, number of byte lanes (≥1)
- COL_WIDTH, 8, bits per lane (8 or 9)
- ADDR_WIDTH, 10, address bits; depth SIZE = 2**ADDR_WIDTH (localparam)
- WRITE_MODE, 0, 0 = write-first, 1 = read-first, 2 = no-change
- OUT_REG, 1, 0 = data on RAM latch only; 1 = extra output register stage
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = no clear
- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, reset; synchronous, active-high
- en, in, 1, access enable; sampled only when ready=1
- we, in, NB_COL, per-lane write enable; lane i covers di[(i+1)*COL_WIDTH-1 : i*COL_WIDTH]
- addr, in, ADDR_WIDTH, word address
- di, in, NB_COL*COL_WIDTH, write data
- do, out, NB_COL*COL_WIDTH, read data
- do_valid, out, 1, one-cycle strobe; do carries new read data
- ready, out, 1, RAM accepts accesses

## Operation
- Reset values: do=0, do_valid=0, ready=0, and all pipeline stages cleared. RAM contents are not reset directly.
- FSM states: CLEAR, RUN.
  - rst=1 forces CLEAR with clear pointer 0.
  - CLEAR writes all-zero to word[ptr], one word per cycle, ptr 0..SIZE-1. After the write to SIZE-1 it moves to RUN, and ready=1 from the next cycle.
  - With CLEAR_ON_RESET=0, the FSM goes directly to RUN, and ready=1 on the first cycle after rst deasserts.
  - rst asserted mid-clear restarts at ptr 0.
- In CLEAR, en/we/addr/di are ignored, and do_valid stays 0.
- Access (en=1 and ready=1):
  - Lanes with we[i]=1 are written with di lane i. Other lanes are unchanged.
  - Write-first: read lane i = we[i] ? di lane i : stored lane i.
  - Read-first: read = stored word before the write.
  - No-change: if any we bit is set, do and do_valid behave as en=0. If we=0, read = stored word.
- en=0: no write, do holds its value, and do_valid is not generated.
- we=0 with en=1 is a pure read in every mode.
- Back-to-back accesses to the same address follow write→read ordering: a read one cycle after a write returns the written lanes.

## Timing
- Latency from the access edge to do/do_valid:
  - OUT_REG=0: 1 cycle.
  - OUT_REG=1: 2 cycles.
- Throughput: one access per cycle while ready=1. There is no backpressure.
- do_valid is high exactly one cycle per qualifying read. The do value persists until the next valid read.
- OUT_REG=1: the second stage is register-enabled and has a valid bit. A bubble (en=0) in the pipe leaves do unchanged.
- rst during a pending read drops it: do_valid stays 0 and do=0 on the next cycle.
- Clear duration: SIZE cycles after rst deasserts, then ready rises.

## Structure
- Package v_rams_pkg holds:
  - write-mode constants WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2;
  - FSM state encodings ST_CLEAR, ST_RUN.
- Sub-module v_rams_clear_seq owns the FSM and clear pointer. It outputs ready, clr_we, clr_addr.
- The top level muxes clear versus user access into the memory array. It generates per-lane write/read logic with a generate loop over NB_COL, and holds the optional output stage.
- The memory array is inferred as block RAM with per-lane write enables. No vendor primitives are instantiated.

## Test plan
- Reset/clear (CLEAR_ON_RESET=1, ADDR_WIDTH=4): assert rst 2 cycles, then release → ready=0 for 16 cycles, then 1. A read of each address returns 0x00000000 with do_valid after 2 cycles (OUT_REG=1).
- Byte writes, write-first: write 0xAABBCCDD with we=4'b1111 to addr 3, then 0x11223344 with we=4'b0101 → do on the second access = 0xAA22CC44. A subsequent read returns 0xAA22CC44.
- Read-first: same sequence with WRITE_MODE=1 → do for the second access = 0xAABBCCDD. The next read returns 0xAA22CC44.
- No-change: WRITE_MODE=2, read addr 5 (=0x01020304), then write addr 5 with we=4'b1000 → do stays 0x01020304, and do_valid is 0 on the write's output cycle.
- Reset mid-clear: assert rst at clear cycle 7 → clear restarts from 0, and ready rises SIZE cycles after release. User writes issued during CLEAR are absent afterwards (reads return 0).
- Pipeline bubbles, OUT_REG=0 vs 1: reads at addresses 1, bubble, 2 → do_valid pulses at cycles t+1, t+3 for OUT_REG=0 and t+2, t+4 for OUT_REG=1, with matching data.

Source files
------------

// File: rtl/v_rams_pkg.sv
// Shared constants for the byte-write single-port RAM: write modes and the
// clear-sequencer state encoding.
package v_rams_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/v_rams_bwe_sp_if.sv
// Access bus of the byte-write single-port RAM, plus the sequencer state for observation.
interface v_rams_bwe_sp_if
  import v_rams_pkg::*;
#(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int DW = NB_COL * COL_WIDTH;

  // An access is taken on every rising edge where en=1 and ready=1; there is
  // no backpressure. do_valid pulses for exactly one cycle per returned read.
  logic                  en;
  logic [NB_COL-1:0]     we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DW-1:0]         di;
  logic [DW-1:0]         dout;
  logic                  do_valid;
  logic                  ready;
  clr_state_e            state;

  modport master (output en, we, addr, di, input dout, do_valid, ready, state);
  modport slave  (input en, we, addr, di, output dout, do_valid, ready, state);

endinterface

// File: rtl/v_rams_clear_seq.sv
// Post-reset clear sequencer: walks every word once writing zero, then
// hands the array over to user accesses.
module v_rams_clear_seq
  import v_rams_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output clr_state_e            state
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      if ((CLEAR_ON_RESET == 0) || (ptr_q == LAST)) state_d = ST_RUN;
      else ptr_d = ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    ready    = (state_q == ST_RUN);
    clr_we   = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    clr_addr = ptr_q;
    state    = state_q;
  end

endmodule

// File: rtl/v_rams_bwe_sp.sv
// Single-port RAM with per-lane write enables, selectable write mode,
// optional output register and zero-fill after reset.
module v_rams_bwe_sp
  import v_rams_pkg::*;
#(
  parameter int NB_COL         = 4,
  parameter int COL_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int WRITE_MODE     = WM_WRITE_FIRST,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            rst,
  v_rams_bwe_sp_if.slave bus
);

  localparam int SIZE = 2 ** ADDR_WIDTH;
  localparam int DW   = NB_COL * COL_WIDTH;

  logic [DW-1:0] mem [SIZE];

  logic                  ready;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  clr_state_e            seq_state;

  v_rams_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (seq_state)
  );

  logic                  access;
  logic                  rd_fire;
  logic [NB_COL-1:0]     wr_lane;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DW-1:0]         wr_data;
  logic [DW-1:0]         stored;
  logic [DW-1:0]         rd_next;

  // No-change mode suppresses the read entirely whenever any lane is written.
  assign access  = bus.en && ready && !rst;
  assign rd_fire = access && ((WRITE_MODE != WM_NO_CHANGE) || (bus.we == '0));
  assign wr_addr = ready ? bus.addr : clr_addr;
  assign stored  = mem[bus.addr];

  for (genvar i = 0; i < NB_COL; i++) begin : g_lane
    assign wr_lane[i] = ready ? (access && bus.we[i]) : clr_we;
    assign wr_data[i*COL_WIDTH +: COL_WIDTH] = ready ? bus.di[i*COL_WIDTH +: COL_WIDTH] : '0;
    if (WRITE_MODE == WM_WRITE_FIRST) begin : g_wf
      assign rd_next[i*COL_WIDTH +: COL_WIDTH] =
        bus.we[i] ? bus.di[i*COL_WIDTH +: COL_WIDTH] : stored[i*COL_WIDTH +: COL_WIDTH];
    end else begin : g_rf
      assign rd_next[i*COL_WIDTH +: COL_WIDTH] = stored[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_COL; i++) begin
      if (wr_lane[i]) mem[wr_addr][i*COL_WIDTH +: COL_WIDTH] <= wr_data[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  logic [DW-1:0] rd_q;
  logic          rd_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= rd_fire;
      if (rd_fire) rd_q <= rd_next;
    end
  end

  // Second stage only loads on a valid beat so bubbles leave dout untouched.
  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] out_q;
    logic          out_v;
    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
        out_v <= 1'b0;
      end else begin
        out_v <= rd_v;
        if (rd_v) out_q <= rd_q;
      end
    end
    assign bus.dout     = out_q;
    assign bus.do_valid = out_v;
  end else begin : g_noreg
    assign bus.dout     = rd_q;
    assign bus.do_valid = rd_v;
  end

  assign bus.ready = ready;
  assign bus.state = seq_state;

endmodule

// File: tb/tb_v_rams_bwe_sp.sv
// Directed bench: four RAM configurations share one stimulus stream, each
// checked against hand-computed expectations.
module tb_v_rams_bwe_sp;
  import v_rams_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  we;
  logic [3:0]  addr;
  logic [31:0] di;

  int n_cmp = 0;
  int n_mis = 0;

  // u0: write-first, OUT_REG=1; u1: read-first, OUT_REG=0;
  // u2: no-change, OUT_REG=0; u3: write-first, no clear.
  v_rams_bwe_sp_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4)) b0 ();
  v_rams_bwe_sp_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4)) b1 ();
  v_rams_bwe_sp_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4)) b2 ();
  v_rams_bwe_sp_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4)) b3 ();

  v_rams_bwe_sp #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(0), .OUT_REG(1),
    .CLEAR_ON_RESET(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  v_rams_bwe_sp #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(1), .OUT_REG(0),
    .CLEAR_ON_RESET(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  v_rams_bwe_sp #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(2), .OUT_REG(0),
    .CLEAR_ON_RESET(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
  v_rams_bwe_sp #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(0), .OUT_REG(0),
    .CLEAR_ON_RESET(0)) u3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.en = en; assign b0.we = we; assign b0.addr = addr; assign b0.di = di;
  assign b1.en = en; assign b1.we = we; assign b1.addr = addr; assign b1.di = di;
  assign b2.en = en; assign b2.we = we; assign b2.addr = addr; assign b2.di = di;
  assign b3.en = en; assign b3.we = we; assign b3.addr = addr; assign b3.di = di;

  logic [31:0] dout_s  [4];
  logic        valid_s [4];
  logic        ready_s [4];

  always_comb begin
    dout_s[0] = b0.dout; valid_s[0] = b0.do_valid; ready_s[0] = b0.ready;
    dout_s[1] = b1.dout; valid_s[1] = b1.do_valid; ready_s[1] = b1.ready;
    dout_s[2] = b2.dout; valid_s[2] = b2.do_valid; ready_s[2] = b2.ready;
    dout_s[3] = b3.dout; valid_s[3] = b3.do_valid; ready_s[3] = b3.ready;
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [3:0] a,
                       input logic [31:0] d);
    en = e; we = w; addr = a; di = d;
  endtask

  // Checking
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input int d, input string tag, input logic v, input logic [31:0] data);
    chk($sformatf("%s_u%0d_valid", tag, d), 32'(valid_s[d]), 32'(v));
    chk($sformatf("%s_u%0d_dout", tag, d), dout_s[d], data);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    step(); step();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_u%0d_ready", d), 32'(ready_s[d]), 32'd0);
      expect_out(d, "rst", 1'b0, 32'h0);
    end

    // First clear, interrupted after seven words; user writes must be ignored.
    rst = 1'b0;
    drive(1'b1, 4'hF, 4'd2, 32'hDEADBEEF);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("clr1_k%0d_u0_ready", k), 32'(ready_s[0]), 32'd0);
      chk($sformatf("clr1_k%0d_u3_ready", k), 32'(ready_s[3]), 32'd1);
    end
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("midrst_u0_ready", 32'(ready_s[0]), 32'd0);
    chk("midrst_u3_ready", 32'(ready_s[3]), 32'd0);

    // Restarted clear: ready must rise exactly 16 edges after release.
    rst = 1'b0;
    drive(1'b1, 4'hF, 4'd0, 32'hDEADBEEF);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("clr2_k%0d_u0_ready", k), 32'(ready_s[0]), (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("clr2_k%0d_u1_ready", k), 32'(ready_s[1]), (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("clr2_k%0d_u2_valid", k), 32'(valid_s[2]), 32'd0);
      chk($sformatf("clr2_k%0d_u3_ready", k), 32'(ready_s[3]), 32'd1);
    end
    drive(1'b0, 4'h0, 4'h0, 32'h0);

    // Every word reads back zero, with latency 1 (u1/u2) and 2 (u0).
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'h0, 4'(a), 32'h0);
      step();
      drive(1'b0, 4'h0, 4'h0, 32'h0);
      expect_out(0, $sformatf("zero_a%0d_c1", a), 1'b0, 32'h0);
      expect_out(1, $sformatf("zero_a%0d_c1", a), 1'b1, 32'h0);
      expect_out(2, $sformatf("zero_a%0d_c1", a), 1'b1, 32'h0);
      step();
      expect_out(0, $sformatf("zero_a%0d_c2", a), 1'b1, 32'h0);
      expect_out(1, $sformatf("zero_a%0d_c2", a), 1'b0, 32'h0);
    end

    // Byte writes to addr 3
    drive(1'b1, 4'hF, 4'd3, 32'hAABBCCDD); step();
    expect_out(0, "bw_e1", 1'b0, 32'h0);
    expect_out(1, "bw_e1", 1'b1, 32'h0);
    expect_out(2, "bw_e1", 1'b0, 32'h0);
    drive(1'b1, 4'h5, 4'd3, 32'h11223344); step();
    expect_out(0, "bw_e2", 1'b1, 32'hAABBCCDD);
    expect_out(1, "bw_e2", 1'b1, 32'hAABBCCDD);
    expect_out(2, "bw_e2", 1'b0, 32'h0);
    drive(1'b1, 4'h0, 4'd3, 32'h0); step();
    expect_out(0, "bw_e3", 1'b1, 32'hAA22CC44);
    expect_out(1, "bw_e3", 1'b1, 32'hAA22CC44);
    expect_out(2, "bw_e3", 1'b1, 32'hAA22CC44);
    drive(1'b0, 4'h0, 4'h0, 32'h0); step();
    expect_out(0, "bw_e4", 1'b1, 32'hAA22CC44);
    expect_out(1, "bw_e4", 1'b0, 32'hAA22CC44);
    step();
    expect_out(0, "bw_e5", 1'b0, 32'hAA22CC44);

    // No-change behaviour at addr 5
    drive(1'b1, 4'hF, 4'd5, 32'h01020304); step();
    expect_out(0, "nc_e1", 1'b0, 32'hAA22CC44);
    expect_out(1, "nc_e1", 1'b1, 32'h0);
    expect_out(2, "nc_e1", 1'b0, 32'hAA22CC44);
    drive(1'b1, 4'h0, 4'd5, 32'h0); step();
    expect_out(0, "nc_e2", 1'b1, 32'h01020304);
    expect_out(1, "nc_e2", 1'b1, 32'h01020304);
    expect_out(2, "nc_e2", 1'b1, 32'h01020304);
    drive(1'b1, 4'h8, 4'd5, 32'hFF000000); step();
    expect_out(0, "nc_e3", 1'b1, 32'h01020304);
    expect_out(1, "nc_e3", 1'b1, 32'h01020304);
    expect_out(2, "nc_e3", 1'b0, 32'h01020304);
    drive(1'b1, 4'h0, 4'd5, 32'h0); step();
    expect_out(0, "nc_e4", 1'b1, 32'hFF020304);
    expect_out(1, "nc_e4", 1'b1, 32'hFF020304);
    expect_out(2, "nc_e4", 1'b1, 32'hFF020304);
    drive(1'b0, 4'h0, 4'h0, 32'h0); step();
    expect_out(0, "nc_e5", 1'b1, 32'hFF020304);
    expect_out(1, "nc_e5", 1'b0, 32'hFF020304);
    expect_out(2, "nc_e5", 1'b0, 32'hFF020304);
    step();
    expect_out(0, "nc_e6", 1'b0, 32'hFF020304);

    // Pipeline bubble: read 1, idle, read 2
    drive(1'b1, 4'hF, 4'd1, 32'hA1A1A1A1); step();
    drive(1'b1, 4'hF, 4'd2, 32'hB2B2B2B2); step();
    drive(1'b0, 4'h0, 4'h0, 32'h0); step(); step();
    drive(1'b1, 4'h0, 4'd1, 32'h0); step();
    expect_out(0, "bub_e1", 1'b0, 32'hB2B2B2B2);
    expect_out(1, "bub_e1", 1'b1, 32'hA1A1A1A1);
    expect_out(2, "bub_e1", 1'b1, 32'hA1A1A1A1);
    drive(1'b0, 4'h0, 4'h0, 32'h0); step();
    expect_out(0, "bub_e2", 1'b1, 32'hA1A1A1A1);
    expect_out(1, "bub_e2", 1'b0, 32'hA1A1A1A1);
    drive(1'b1, 4'h0, 4'd2, 32'h0); step();
    expect_out(0, "bub_e3", 1'b0, 32'hA1A1A1A1);
    expect_out(1, "bub_e3", 1'b1, 32'hB2B2B2B2);
    expect_out(2, "bub_e3", 1'b1, 32'hB2B2B2B2);
    drive(1'b0, 4'h0, 4'h0, 32'h0); step();
    expect_out(0, "bub_e4", 1'b1, 32'hB2B2B2B2);
    expect_out(1, "bub_e4", 1'b0, 32'hB2B2B2B2);
    step();
    expect_out(0, "bub_e5", 1'b0, 32'hB2B2B2B2);

    // Reset while a read is still in the u0 pipe drops it
    drive(1'b1, 4'h0, 4'd1, 32'h0); step();
    expect_out(0, "prst_e1", 1'b0, 32'hB2B2B2B2);
    expect_out(1, "prst_e1", 1'b1, 32'hA1A1A1A1);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    expect_out(0, "prst_e2", 1'b0, 32'h0);
    expect_out(1, "prst_e2", 1'b0, 32'h0);
    step();
    expect_out(0, "prst_e3", 1'b0, 32'h0);
    rst = 1'b0;

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
